// File: rtl/timer_pkg.sv
// timer_pkg: address map, reset values and TCSR flag layout shared by the timer register file.
package timer_pkg;
   localparam int A_TCR0 = 0, A_TCR1 = 1, A_TCSR0 = 2, A_TCSR1 = 3, A_TCORA0 = 4, A_TCORA1 = 5;
   localparam int A_TCORB0 = 6, A_TCORB1 = 7, A_TCCR0 = 8, A_TCCR1 = 9, N_REGS = 10;
   localparam logic [7:0] TCR_RST = 8'h00, TCCR_RST = 8'h00, TCOR_RST = 8'hFF;
   localparam logic [7:0] TCCR_WMASK = 8'h0B;
   localparam logic [4:0] TCSR0_WMASK = 5'h1F, TCSR1_WMASK = 5'h0F;
   localparam int CMFB_BIT = 7, CMFA_BIT = 6, OVF_BIT = 5;
   typedef enum logic {IDLE, ACK} bus_state_t;
   function automatic logic [7:0] pack_tcsr(input logic [2:0] f, input logic [4:0] lo);
      logic [7:0] v;
      v = {3'b000, lo};
      v[CMFB_BIT] = f[2];
      v[CMFA_BIT] = f[1];
      v[OVF_BIT] = f[0];
      return v;
   endfunction
   function automatic logic is_mapped(input int unsigned a);
      return a < N_REGS;
   endfunction
endpackage

// File: rtl/timer_reg_file_if.sv
// timer_reg_file_if: request/ack register bus; bus_err exists only when TMR_BUS_ERR_EN is defined.
interface timer_reg_file_if #(parameter int BIT_WIDTH = 8, parameter int ADDR_WIDTH = 4);
   logic bus_req;
   logic bus_we;
   logic [ADDR_WIDTH-1:0] bus_addr;
   logic [BIT_WIDTH-1:0] bus_wdata;
   logic bus_ack;
   logic [BIT_WIDTH-1:0] bus_rdata;
`ifdef TMR_BUS_ERR_EN
   logic bus_err;
`endif
   modport master(output bus_req, bus_we, bus_addr, bus_wdata, input bus_ack, bus_rdata
`ifdef TMR_BUS_ERR_EN
      , input bus_err
`endif
   );
   modport slave(input bus_req, bus_we, bus_addr, bus_wdata, output bus_ack, bus_rdata
`ifdef TMR_BUS_ERR_EN
      , output bus_err
`endif
   );
endinterface

// File: rtl/timer_flag_ch.sv
// timer_flag_ch: one channel's CMFB/CMFA/OVF flags (bits 2/1/0) with read-arms, write-0-clears semantics.
module timer_flag_ch (
   input logic clk,
   input logic rst,
   input logic [2:0] set,
   input logic rd,
   input logic wr,
   input logic [2:0] wd,
   output logic [2:0] flags
);
   logic [2:0] arm;
   always_ff @(posedge clk) begin
      if (rst) begin
         flags <= '0;
         arm <= '0;
      end else begin
         // a set event always wins; any write of 0 disarms so a fresh read is needed
         flags <= set | (flags & ~(arm & ~wd & {3{wr}}));
         arm <= wr ? (arm & wd) : rd ? (arm | flags) : arm;
      end
   end
endmodule

// File: rtl/timer_reg_file.sv
// timer_reg_file: two-channel timer register file on a req/ack bus.
// Optional TMR_BUS_ERR_EN adds bus_err for accesses to unmapped addresses.
module timer_reg_file
   import timer_pkg::*;
#(
   parameter int BIT_WIDTH = 8,
   parameter int ADDR_WIDTH = 4
) (
   input logic clk,
   input logic rst,
   timer_reg_file_if.slave bus,
   input logic CompareMatchA0,
   input logic CompareMatchA1,
   input logic CompareMatchB0,
   input logic CompareMatchB1,
   input logic Overflow0,
   input logic Overflow1,
   output logic [BIT_WIDTH-1:0] TCR_0,
   output logic [BIT_WIDTH-1:0] TCR_1,
   output logic [BIT_WIDTH-1:0] TCCR_0,
   output logic [BIT_WIDTH-1:0] TCCR_1,
   output logic [BIT_WIDTH-1:0] TCSR_0,
   output logic [BIT_WIDTH-1:0] TCSR_1,
   output logic [BIT_WIDTH-1:0] TCORA_0,
   output logic [BIT_WIDTH-1:0] TCORA_1,
   output logic [BIT_WIDTH-1:0] TCORB_0,
   output logic [BIT_WIDTH-1:0] TCORB_1
);
   bus_state_t state;
   logic [4:0] lo0, lo1;
   logic [2:0] f0, f1, wd;
   logic [BIT_WIDTH-1:0] rd_val;
   logic acc, wr, rd, sel0, sel1;
   assign acc = state == IDLE && bus.bus_req;
   assign wr = acc && bus.bus_we;
   assign rd = acc && !bus.bus_we;
   assign sel0 = bus.bus_addr == ADDR_WIDTH'(A_TCSR0);
   assign sel1 = bus.bus_addr == ADDR_WIDTH'(A_TCSR1);
   assign wd = {bus.bus_wdata[CMFB_BIT], bus.bus_wdata[CMFA_BIT], bus.bus_wdata[OVF_BIT]};
   timer_flag_ch u_ch0 (.clk(clk), .rst(rst), .set({CompareMatchB0, CompareMatchA0, Overflow0}),
      .rd(rd && sel0), .wr(wr && sel0), .wd(wd), .flags(f0));
   timer_flag_ch u_ch1 (.clk(clk), .rst(rst), .set({CompareMatchB1, CompareMatchA1, Overflow1}),
      .rd(rd && sel1), .wr(wr && sel1), .wd(wd), .flags(f1));
   assign TCSR_0 = BIT_WIDTH'(pack_tcsr(f0, lo0));
   assign TCSR_1 = BIT_WIDTH'(pack_tcsr(f1, lo1));
   always_comb begin
      rd_val = '0;
      case (bus.bus_addr)
         ADDR_WIDTH'(A_TCR0): rd_val = TCR_0;
         ADDR_WIDTH'(A_TCR1): rd_val = TCR_1;
         ADDR_WIDTH'(A_TCSR0): rd_val = TCSR_0;
         ADDR_WIDTH'(A_TCSR1): rd_val = TCSR_1;
         ADDR_WIDTH'(A_TCORA0): rd_val = TCORA_0;
         ADDR_WIDTH'(A_TCORA1): rd_val = TCORA_1;
         ADDR_WIDTH'(A_TCORB0): rd_val = TCORB_0;
         ADDR_WIDTH'(A_TCORB1): rd_val = TCORB_1;
         ADDR_WIDTH'(A_TCCR0): rd_val = TCCR_0;
         ADDR_WIDTH'(A_TCCR1): rd_val = TCCR_1;
         default: rd_val = '0;
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bus.bus_ack <= 1'b0;
         bus.bus_rdata <= '0;
`ifdef TMR_BUS_ERR_EN
         bus.bus_err <= 1'b0;
`endif
         TCR_0 <= BIT_WIDTH'(TCR_RST);
         TCR_1 <= BIT_WIDTH'(TCR_RST);
         TCCR_0 <= BIT_WIDTH'(TCCR_RST);
         TCCR_1 <= BIT_WIDTH'(TCCR_RST);
         TCORA_0 <= BIT_WIDTH'(TCOR_RST);
         TCORA_1 <= BIT_WIDTH'(TCOR_RST);
         TCORB_0 <= BIT_WIDTH'(TCOR_RST);
         TCORB_1 <= BIT_WIDTH'(TCOR_RST);
         lo0 <= '0;
         lo1 <= '0;
      end else begin
         // ACK always returns to IDLE, so requests during ACK are dropped
         state <= acc ? ACK : IDLE;
         bus.bus_ack <= acc;
         bus.bus_rdata <= acc ? rd_val : '0;
`ifdef TMR_BUS_ERR_EN
         bus.bus_err <= acc && !is_mapped(32'(bus.bus_addr));
`endif
         if (wr) begin
            case (bus.bus_addr)
               ADDR_WIDTH'(A_TCR0): TCR_0 <= bus.bus_wdata;
               ADDR_WIDTH'(A_TCR1): TCR_1 <= bus.bus_wdata;
               ADDR_WIDTH'(A_TCSR0): lo0 <= bus.bus_wdata[4:0] & TCSR0_WMASK;
               ADDR_WIDTH'(A_TCSR1): lo1 <= bus.bus_wdata[4:0] & TCSR1_WMASK;
               ADDR_WIDTH'(A_TCORA0): TCORA_0 <= bus.bus_wdata;
               ADDR_WIDTH'(A_TCORA1): TCORA_1 <= bus.bus_wdata;
               ADDR_WIDTH'(A_TCORB0): TCORB_0 <= bus.bus_wdata;
               ADDR_WIDTH'(A_TCORB1): TCORB_1 <= bus.bus_wdata;
               ADDR_WIDTH'(A_TCCR0): TCCR_0 <= bus.bus_wdata & BIT_WIDTH'(TCCR_WMASK);
               ADDR_WIDTH'(A_TCCR1): TCCR_1 <= bus.bus_wdata & BIT_WIDTH'(TCCR_WMASK);
               default: ;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_timer_reg_file.sv
// tb_timer_reg_file: directed and random stimulus against a register-map model of timer_reg_file.
// Build with TMR_BUS_ERR_EN defined to also check bus_err.
module tb_timer_reg_file;
   logic clk = 1'b0;
   logic rst, req, we;
   logic [3:0] addr;
   logic [7:0] wdata;
   logic [1:0] cma, cmb, ovf;
   logic [7:0] TCR_0, TCR_1, TCCR_0, TCCR_1, TCSR_0, TCSR_1, TCORA_0, TCORA_1, TCORB_0, TCORB_1;
   int n_cmp = 0, n_bad = 0;
   logic [7:0] m_reg [10];
   logic [7:0] m_arm [2];
   logic m_busy, m_ack, m_err;
   logic [7:0] m_rdata;

   always #5 clk = ~clk;

   timer_reg_file_if #(.BIT_WIDTH(8), .ADDR_WIDTH(4)) bus ();
   assign bus.bus_req = req;
   assign bus.bus_we = we;
   assign bus.bus_addr = addr;
   assign bus.bus_wdata = wdata;

   timer_reg_file #(.BIT_WIDTH(8), .ADDR_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .CompareMatchA0(cma[0]), .CompareMatchA1(cma[1]),
      .CompareMatchB0(cmb[0]), .CompareMatchB1(cmb[1]),
      .Overflow0(ovf[0]), .Overflow1(ovf[1]),
      .TCR_0(TCR_0), .TCR_1(TCR_1), .TCCR_0(TCCR_0), .TCCR_1(TCCR_1),
      .TCSR_0(TCSR_0), .TCSR_1(TCSR_1), .TCORA_0(TCORA_0), .TCORA_1(TCORA_1),
      .TCORB_0(TCORB_0), .TCORB_1(TCORB_1)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Register-map view: one byte per address, flag bits plus per-flag arm bits.
   task automatic model_edge();
      logic acc, wrc, rdc, old;
      logic [7:0] rv, ev;
      int a;
      a = int'(addr);
      if (rst) begin
         for (int i = 0; i < 10; i++) m_reg[i] = (i >= 4 && i <= 7) ? 8'hFF : 8'h00;
         m_arm[0] = 8'h00;
         m_arm[1] = 8'h00;
         m_busy = 1'b0;
         m_ack = 1'b0;
         m_rdata = 8'h00;
         m_err = 1'b0;
      end else begin
         acc = !m_busy && req;
         rv = (acc && a < 10) ? m_reg[a] : 8'h00;
         for (int c = 0; c < 2; c++) begin
            ev = {cmb[c], cma[c], ovf[c], 5'b00000};
            wrc = acc && we && a == 2 + c;
            rdc = acc && !we && a == 2 + c;
            for (int b = 5; b < 8; b++) begin
               old = m_reg[2 + c][b];
               if (ev[b]) m_reg[2 + c][b] = 1'b1;
               else if (wrc && m_arm[c][b] && !wdata[b]) m_reg[2 + c][b] = 1'b0;
               if (wrc && !wdata[b]) m_arm[c][b] = 1'b0;
               else if (rdc && old) m_arm[c][b] = 1'b1;
            end
         end
         if (acc && we && a < 10) begin
            if (a == 2) m_reg[2] = {m_reg[2][7:5], wdata[4:0]};
            else if (a == 3) m_reg[3] = {m_reg[3][7:5], 1'b0, wdata[3:0]};
            else if (a >= 8) m_reg[a] = wdata & 8'h0B;
            else m_reg[a] = wdata;
         end
         m_ack = acc;
         m_rdata = rv;
         m_err = acc && a >= 10;
         m_busy = acc;
      end
   endtask

   task automatic check_all();
      chk("ack", 32'(bus.bus_ack), 32'(m_ack));
      chk("rdata", 32'(bus.bus_rdata), 32'(m_rdata));
`ifdef TMR_BUS_ERR_EN
      chk("err", 32'(bus.bus_err), 32'(m_err));
`endif
      chk("TCR_0", 32'(TCR_0), 32'(m_reg[0]));
      chk("TCR_1", 32'(TCR_1), 32'(m_reg[1]));
      chk("TCSR_0", 32'(TCSR_0), 32'(m_reg[2]));
      chk("TCSR_1", 32'(TCSR_1), 32'(m_reg[3]));
      chk("TCORA_0", 32'(TCORA_0), 32'(m_reg[4]));
      chk("TCORA_1", 32'(TCORA_1), 32'(m_reg[5]));
      chk("TCORB_0", 32'(TCORB_0), 32'(m_reg[6]));
      chk("TCORB_1", 32'(TCORB_1), 32'(m_reg[7]));
      chk("TCCR_0", 32'(TCCR_0), 32'(m_reg[8]));
      chk("TCCR_1", 32'(TCCR_1), 32'(m_reg[9]));
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all();
      cma = 2'b00;
      cmb = 2'b00;
      ovf = 2'b00;
   endtask

   // Drives one accepted request; returns at the ACK-cycle sample point with req dropped.
   task automatic access(input logic w, input logic [3:0] a, input logic [7:0] d);
      req = 1'b1;
      we = w;
      addr = a;
      wdata = d;
      cycle();
      req = 1'b0;
   endtask

   initial begin
      int n;
      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;
      cma = '0; cmb = '0; ovf = '0;
      @(negedge clk);
      cycle();
      cycle();
      chk("rst_TCORA_0", 32'(TCORA_0), 32'hFF);
      chk("rst_TCR_0", 32'(TCR_0), 32'h00);
      chk("rst_ack", 32'(bus.bus_ack), 32'h0);
      rst = 1'b0;
      cycle();
      access(1'b0, 4'd4, 8'h00);
      chk("r4_ack", 32'(bus.bus_ack), 32'h1);
      chk("r4_rdata", 32'(bus.bus_rdata), 32'hFF);
      cycle();
      chk("r4_ack_drop", 32'(bus.bus_ack), 32'h0);
      access(1'b0, 4'd0, 8'h00);
      chk("r0_rdata", 32'(bus.bus_rdata), 32'h00);
      cycle();
      access(1'b1, 4'd0, 8'hE5);
      chk("w0_TCR_0", 32'(TCR_0), 32'hE5);
      cycle();
      access(1'b0, 4'd0, 8'h00);
      chk("r0_E5", 32'(bus.bus_rdata), 32'hE5);
      cycle();
      access(1'b1, 4'd8, 8'hFF);
      chk("w8_TCCR_0", 32'(TCCR_0), 32'h0B);
      cycle();
      access(1'b0, 4'd8, 8'h00);
      chk("r8_TCCR_0", 32'(bus.bus_rdata), 32'h0B);
      cycle();
      cma[0] = 1'b1;
      cycle();
      chk("cmfa0_set", 32'(TCSR_0[6]), 32'h1);
      access(1'b0, 4'd2, 8'h00);
      chk("r2_cmfa0", 32'(bus.bus_rdata), 32'h40);
      cycle();
      access(1'b1, 4'd2, 8'h00);
      chk("cmfa0_clear", 32'(TCSR_0[6]), 32'h0);
      cycle();
      cma[0] = 1'b1;
      cycle();
      access(1'b1, 4'd2, 8'h00);
      chk("cmfa0_unarmed", 32'(TCSR_0[6]), 32'h1);
      cycle();
      ovf[1] = 1'b1;
      cycle();
      access(1'b0, 4'd3, 8'h00);
      chk("r3_ovf1", 32'(bus.bus_rdata), 32'h20);
      cycle();
      ovf[1] = 1'b1;
      access(1'b1, 4'd3, 8'h00);
      chk("ovf1_set_wins", 32'(TCSR_1[5]), 32'h1);
      cycle();
      access(1'b1, 4'd3, 8'h00);
      chk("ovf1_disarmed", 32'(TCSR_1[5]), 32'h1);
      cycle();
      access(1'b1, 4'd3, 8'hFF);
      chk("w3_TCSR_1", 32'(TCSR_1), 32'h2F);
      cycle();
      req = 1'b1; we = 1'b0; addr = 4'd4; n = 0;
      for (int i = 0; i < 6; i++) begin
         cycle();
         if (bus.bus_ack) n++;
      end
      req = 1'b0;
      chk("hold_acks", 32'(n), 32'd3);
      cycle();
      access(1'b1, 4'd4, 8'h12);
      rst = 1'b1;
      cycle();
      chk("rst_in_ack", 32'(bus.bus_ack), 32'h0);
      chk("rst_TCORA_0b", 32'(TCORA_0), 32'hFF);
      chk("rst_TCSR_1", 32'(TCSR_1), 32'h00);
      req = 1'b1; we = 1'b1; addr = 4'd0; wdata = 8'hAA;
      cycle();
      chk("rst_abort_ack", 32'(bus.bus_ack), 32'h0);
      chk("rst_abort_TCR_0", 32'(TCR_0), 32'h00);
      rst = 1'b0; req = 1'b0;
      cycle();
      access(1'b0, 4'd12, 8'h00);
      chk("rC_rdata", 32'(bus.bus_rdata), 32'h00);
`ifdef TMR_BUS_ERR_EN
      chk("rC_err", 32'(bus.bus_err), 32'h1);
`endif
      cycle();
      access(1'b1, 4'd12, 8'h5A);
      cycle();
      for (int i = 0; i < 3000; i++) begin
         rst = $urandom_range(99) == 0;
         req = $urandom_range(2) != 0;
         we = 1'(($urandom_range(1)));
         addr = ($urandom_range(2) == 0) ? 4'(2 + $urandom_range(1)) : 4'($urandom_range(15));
         wdata = 8'($urandom);
         cma = {$urandom_range(4) == 0, $urandom_range(4) == 0};
         cmb = {$urandom_range(4) == 0, $urandom_range(4) == 0};
         ovf = {$urandom_range(4) == 0, $urandom_range(4) == 0};
         cycle();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/timer_reg_file.md
TIMER_REG_FILE -- requirements
Module: timer_reg_file

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 8, register and data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, bus address width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have ports bus_req / bus_we, input, 1 each: access request and write (1) or read (0).
REQ-006 SHALL have ports bus_addr (input, ADDR_WIDTH) and bus_wdata (input, BIT_WIDTH).
REQ-007 SHALL have ports bus_ack (output, 1) and bus_rdata (output, BIT_WIDTH).
REQ-008 SHALL have inputs CompareMatchA0/A1, CompareMatchB0/B1, Overflow0/1, 1 each: single-cycle event pulses from the counter datapath.
REQ-009 SHALL have outputs TCR_0/1, TCCR_0/1, TCSR_0/1, TCORA_0/1, TCORB_0/1, BIT_WIDTH each: register contents driven straight from flops.

Function
REQ-010 SHALL use this address map: 0 TCR_0, 1 TCR_1, 2 TCSR_0, 3 TCSR_1, 4 TCORA_0, 5 TCORA_1, 6 TCORB_0, 7 TCORB_1, 8 TCCR_0, 9 TCCR_1; 10-15 unmapped.
REQ-011 SHALL implement handshake states IDLE -> ACK -> IDLE: bus_req=1 in IDLE is accepted; bus_ack=1 for exactly the next cycle; bus_req during ACK is ignored (max one access per 2 cycles).
REQ-012 SHALL commit a write on the accept edge; the new value is visible on the register output in the ACK cycle.
REQ-013 SHALL drive bus_rdata with the addressed value, sampled at accept, only during ACK; 0 otherwise.
REQ-014 SHALL return 0 on reads of unmapped addresses and ignore writes to them.
REQ-015 SHALL treat TCR, TCORA, TCORB as plain R/W; TCCR bits 7:4 and 2 read 0 and ignore writes.
REQ-016 SHALL treat TCSR bits 3:0 and TCSR_0 bit 4 as plain R/W; TCSR_1 bit 4 reads 0 and ignores writes.
REQ-017 SHALL set flag CMFB (bit 7), CMFA (bit 6), OVF (bit 5) of channel n on the edge after CompareMatchBn, CompareMatchAn, Overflown is 1 respectively.
REQ-018 SHALL arm a flag's clear when a TCSR read returns that flag as 1; writing 1 to a flag bit has no effect.
REQ-019 SHALL clear a flag and disarm it when TCSR is written with that bit 0 while armed; writing 0 when unarmed leaves the flag unchanged.
REQ-020 SHALL keep the flag at 1 and disarm it when a set event coincides with a clearing write (set wins; new read required).
REQ-021 SHALL keep the arm state unchanged on a set event while the flag is already 1 with no concurrent write.
REQ-022 SHALL handle channels 0 and 1 independently; simultaneous events on both set both flags the same cycle.

Reset
REQ-023 SHALL, while rst=1, force TCR, TCCR, TCSR to 0x00, TCORA/TCORB to 0xFF, arm bits to 0, state to IDLE, bus_ack and bus_rdata to 0.
REQ-024 SHALL abort an in-flight access on rst (no ack), with rst taking priority over events and writes in the same cycle.

Configuration
REQ-025 SHALL, with TMR_BUS_ERR_EN defined, add output bus_err (1 bit), high with bus_ack in the ACK cycle of an unmapped-address access, else 0, reset 0.
REQ-026 SHALL, without TMR_BUS_ERR_EN, have no bus_err port and identical other behaviour.

Structure
REQ-027 SHALL take address constants, register reset values, and TCSR flag bit positions from shared package timer_pkg.
REQ-028 SHALL implement per-channel flag set/arm/clear logic in sub-module timer_flag_ch, instantiated once per channel.

Verification
REQ-029 SHALL cover: reset, then read addr 4 -> bus_ack one cycle after req, bus_rdata=0xFF; addr 0 reads 0x00.
REQ-030 SHALL cover: write 0xE5 to addr 0, then read -> TCR_0=0xE5 in ACK cycle, read returns 0xE5; write 0xFF to addr 8 -> TCCR_0 reads 0x0B.
REQ-031 SHALL cover: pulse CompareMatchA0, read addr 2 (0x40), write 0x00 -> TCSR_0 bit 6 cleared; write 0x00 without prior read -> bit 6 stays 1.
REQ-032 SHALL cover: after arming OVF_1 (TCSR_1=0x20), Overflow1 pulse in the write-accept cycle with data 0x00 -> bit 5 stays 1; a following 0x00 write alone leaves it 1.
REQ-033 SHALL cover: bus_req held high 6 cycles -> exactly 3 acks on alternate cycles; rst asserted in ACK -> ack drops the next cycle, registers at reset values.
REQ-034 SHALL cover, with TMR_BUS_ERR_EN: read addr 0xC -> bus_rdata=0, bus_err=1 in ACK cycle; without the macro, same read -> bus_rdata=0.
